sipo_word_assembler: RTL and testbench



---
 rtl/sipo_word_assembler.sv | 103 ++++++++++
 tb/tb_sipo_word_assembler.sv | 204 ++++++++++++++++++++
 2 files changed

// File: rtl/sipo_word_assembler.sv
// Serial-in, parallel-out word assembler: gathers one bit per enabled clock into a
// WIDTH-bit word and hands completed words to a consumer through a one-deep output register.
module sipo_word_assembler #(
  parameter int WIDTH     = 8,
  parameter bit MSB_FIRST = 1'b1
) (
  input  logic                     clk,
  input  logic                     clr_n,
  input  logic                     sin,
  input  logic                     sin_en,
  input  logic                     flush,
  output logic [WIDTH-1:0]         word,
  output logic                     word_valid,
  input  logic                     word_ack,
  output logic [$clog2(WIDTH)-1:0] bit_count,
  output logic                     overrun,
  input  logic                     overrun_clr
);

  localparam int CW = $clog2(WIDTH);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  // Handshake: word_valid=1 means word holds an unconsumed value; the consumer takes it on
  // any rising edge where word_valid=1 and word_ack=1. word is stable from valid rising
  // until that edge; word_ack while word_valid=0 has no effect.
  typedef enum logic {
    EMPTY = 1'b0,
    FULL  = 1'b1
  } state_t;

  state_t           state, state_nxt;
  logic [WIDTH-1:0] sh, sh_shifted, sh_nxt;
  logic [CW-1:0]    cnt_nxt;
  logic             take, complete, load, drop, ovr_nxt;

  generate
    if (MSB_FIRST) begin : g_msb
      assign sh_shifted = {sh[WIDTH-2:0], sin};
    end else begin : g_lsb
      assign sh_shifted = {sin, sh[WIDTH-1:1]};
    end
  endgenerate

  // flush overrides sin_en, so a flushed edge can never complete a word
  assign take     = sin_en & ~flush;
  assign complete = take & (bit_count == LAST);

  always_comb begin
    sh_nxt  = sh;
    cnt_nxt = bit_count;
    if (flush) begin
      cnt_nxt = '0;
    end else if (take) begin
      sh_nxt  = sh_shifted;
      cnt_nxt = complete ? '0 : bit_count + 1'b1;
    end
  end

  always_comb begin
    state_nxt = state;
    load      = 1'b0;
    drop      = 1'b0;
    case (state)
      EMPTY: begin
        if (complete) begin
          load      = 1'b1;
          state_nxt = FULL;
        end
      end
      FULL: begin
        if (complete) begin
          if (word_ack) load = 1'b1;
          else          drop = 1'b1;
        end else if (word_ack) begin
          state_nxt = EMPTY;
        end
      end
      default: state_nxt = EMPTY;
    endcase
  end

  // A drop on the same edge as overrun_clr keeps the flag set
  assign ovr_nxt = drop | (overrun & ~overrun_clr);

  always_ff @(posedge clk or negedge clr_n) begin
    if (!clr_n) begin
      state     <= EMPTY;
      sh        <= '0;
      bit_count <= '0;
      word      <= '0;
      overrun   <= 1'b0;
    end else begin
      state     <= state_nxt;
      sh        <= sh_nxt;
      bit_count <= cnt_nxt;
      overrun   <= ovr_nxt;
      if (load) word <= sh_shifted;
    end
  end

  assign word_valid = (state == FULL);

endmodule

// File: tb/tb_sipo_word_assembler.sv
// Bench for sipo_word_assembler: an MSB-first and an LSB-first instance share one stimulus
// stream and are compared every cycle against a bit-queue model of the word assembly.
module tb_sipo_word_assembler;

  localparam int W = 8;

  logic         clk = 1'b0;
  logic         clr_n = 1'b1;
  logic         sin = 1'b0, sin_en = 1'b0, flush = 1'b0, word_ack = 1'b0, overrun_clr = 1'b0;
  logic [W-1:0] word_m, word_l;
  logic         valid_m, valid_l, ovr_m, ovr_l;
  logic [2:0]   cnt_m, cnt_l;

  int n_total = 0;
  int n_pass  = 0;
  bit chk_en  = 1'b0;

  always #5 clk = ~clk;

  sipo_word_assembler #(.WIDTH(W), .MSB_FIRST(1'b1)) u_msb (
    .clk(clk), .clr_n(clr_n), .sin(sin), .sin_en(sin_en), .flush(flush),
    .word(word_m), .word_valid(valid_m), .word_ack(word_ack), .bit_count(cnt_m),
    .overrun(ovr_m), .overrun_clr(overrun_clr)
  );

  sipo_word_assembler #(.WIDTH(W), .MSB_FIRST(1'b0)) u_lsb (
    .clk(clk), .clr_n(clr_n), .sin(sin), .sin_en(sin_en), .flush(flush),
    .word(word_l), .word_valid(valid_l), .word_ack(word_ack), .bit_count(cnt_l),
    .overrun(ovr_l), .overrun_clr(overrun_clr)
  );

  // Reference model: received bits in arrival order; a word forms when W bits are held
  logic         m_bits[$];
  logic         m_valid = 1'b0;
  logic         m_ovr   = 1'b0;
  logic [W-1:0] m_wm    = '0;
  logic [W-1:0] m_wl    = '0;

  always @(posedge clk or negedge clr_n) begin
    logic         done, drop;
    logic [W-1:0] cm, cl;
    if (!clr_n) begin
      m_bits.delete();
      m_valid = 1'b0;
      m_ovr   = 1'b0;
      m_wm    = '0;
      m_wl    = '0;
    end else begin
      done = 1'b0;
      cm   = '0;
      cl   = '0;
      if (flush) begin
        m_bits.delete();
      end else if (sin_en) begin
        m_bits.push_back(sin);
        if (m_bits.size() == W) begin
          done = 1'b1;
          for (int i = 0; i < W; i++) begin
            cm[W-1-i] = m_bits[i];
            cl[i]     = m_bits[i];
          end
          m_bits.delete();
        end
      end
      drop = done && m_valid && !word_ack;
      if (overrun_clr) m_ovr = 1'b0;
      if (drop)        m_ovr = 1'b1;
      if (done && !drop) begin
        m_wm    = cm;
        m_wl    = cl;
        m_valid = 1'b1;
      end else if (m_valid && word_ack && !done) begin
        m_valid = 1'b0;
      end
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
  endtask

  // Per-cycle comparison against the model
  always @(negedge clk) begin
    if (chk_en) begin
      check("valid_m", {31'd0, valid_m}, {31'd0, m_valid});
      check("valid_l", {31'd0, valid_l}, {31'd0, m_valid});
      check("ovr_m", {31'd0, ovr_m}, {31'd0, m_ovr});
      check("ovr_l", {31'd0, ovr_l}, {31'd0, m_ovr});
      check("cnt_m", {29'd0, cnt_m}, m_bits.size());
      check("cnt_l", {29'd0, cnt_l}, m_bits.size());
      if (m_valid) begin
        check("word_m", {24'd0, word_m}, {24'd0, m_wm});
        check("word_l", {24'd0, word_l}, {24'd0, m_wl});
      end
    end
  end

  function automatic logic [W-1:0] rev(input logic [W-1:0] v);
    for (int i = 0; i < W; i++) rev[i] = v[W-1-i];
  endfunction

  task automatic step(input logic b, input logic en, input logic fl, input logic ak, input logic oc);
    sin = b; sin_en = en; flush = fl; word_ack = ak; overrun_clr = oc;
    @(negedge clk);
    sin_en = 1'b0; flush = 1'b0; word_ack = 1'b0; overrun_clr = 1'b0;
  endtask

  // Sends v MSB first on the wire; ack/oclr are applied on the completion edge
  task automatic send_byte(input logic [W-1:0] v, input int gap, input logic ak, input logic oc);
    for (int i = W - 1; i >= 0; i--) begin
      step(v[i], 1'b1, 1'b0, (i == 0) ? ak : 1'b0, (i == 0) ? oc : 1'b0);
      if (i != 0) for (int g = 0; g < gap; g++) step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    end
  endtask

  task automatic expect_word(input string name, input logic [W-1:0] v, input logic ovr);
    check({name, "_valid"}, {31'd0, valid_m}, 32'd1);
    check({name, "_word_m"}, {24'd0, word_m}, {24'd0, v});
    check({name, "_word_l"}, {24'd0, word_l}, {24'd0, rev(v)});
    check({name, "_ovr"}, {31'd0, ovr_m}, {31'd0, ovr});
  endtask

  initial begin
    #1 clr_n = 1'b0;
    chk_en = 1'b1;
    repeat (2) @(negedge clk);
    clr_n = 1'b1;
    @(negedge clk);

    // Reset mid-word
    send_byte(8'h00, 0, 1'b0, 1'b0);
    step(1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
    step(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    step(1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
    check("pre_rst_cnt", {29'd0, cnt_m}, 32'd3);
    #3 clr_n = 1'b0;
    #1;
    check("rst_cnt", {29'd0, cnt_m}, 32'd0);
    check("rst_valid", {31'd0, valid_m}, 32'd0);
    check("rst_word", {24'd0, word_m}, 32'd0);
    check("rst_ovr", {31'd0, ovr_m}, 32'd0);
    @(negedge clk);
    clr_n = 1'b1;
    step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    send_byte(8'h5A, 0, 1'b0, 1'b0);
    expect_word("fresh", 8'h5A, 1'b0);
    step(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    check("ack_empty", {31'd0, valid_m}, 32'd0);

    // Palindromic pattern: same word in both bit orders
    send_byte(8'hA5, 0, 1'b0, 1'b0);
    expect_word("a5", 8'hA5, 1'b0);
    check("a5_word_l_lit", {24'd0, word_l}, 32'hA5);
    step(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);

    // Gapped enables
    send_byte(8'h3C, 2, 1'b0, 1'b0);
    expect_word("gap", 8'h3C, 1'b0);
    step(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);

    // Stall overrun, then clear coinciding with another drop
    send_byte(8'h11, 0, 1'b0, 1'b0);
    send_byte(8'h22, 0, 1'b0, 1'b0);
    expect_word("stall", 8'h11, 1'b1);
    send_byte(8'h33, 0, 1'b0, 1'b1);
    expect_word("clr_vs_drop", 8'h11, 1'b1);
    step(1'b0, 1'b0, 1'b0, 1'b1, 1'b1);
    check("ovr_cleared", {31'd0, ovr_m}, 32'd0);

    // Ack on the completion edge of a back-to-back word
    send_byte(8'h11, 0, 1'b0, 1'b0);
    send_byte(8'h22, 0, 1'b1, 1'b0);
    expect_word("b2b", 8'h22, 1'b0);
    step(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);

    // Flush together with sin_en after 5 bits
    for (int i = 0; i < 5; i++) step(1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
    step(1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
    check("flush_cnt", {29'd0, cnt_m}, 32'd0);
    check("flush_valid", {31'd0, valid_m}, 32'd0);
    send_byte(8'hFF, 0, 1'b0, 1'b0);
    expect_word("post_flush", 8'hFF, 1'b0);
    step(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);

    // Randomised traffic
    for (int n = 0; n < 600; n++) begin
      step(1'($urandom_range(1, 0)), ($urandom_range(99, 0) < 70),
           ($urandom_range(99, 0) < 3), ($urandom_range(99, 0) < 35),
           ($urandom_range(99, 0) < 5));
      if (n == 300) begin
        #2 clr_n = 1'b0;
        @(negedge clk);
        clr_n = 1'b1;
      end
    end

    chk_en = 1'b0;
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
